ex_csr_rmw: RTL

Multi-cycle CSR read-modify-write engine in the execute stage. It is parametrised in data width and CSR-file read latency. It accepts one Zicsr instruction at a time over a valid/ready handshake, reads the old CSR value, computes the new value, and writes it back. It returns the old value for rd to the writeback path. It suppresses side-effect-free reads and writes per the RISC-V spec, flags illegal accesses, and supports pipeline flush before commit.

---
 rtl/ex_csr_rmw_pkg.sv | 36 +++
 rtl/ex_csr_alu.sv | 51 +++++
 rtl/ex_csr_rmw.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_csr_rmw_pkg.sv
// Shared encodings and types for the execute-stage CSR read-modify-write path.
package ex_csr_rmw_pkg;

    localparam int unsigned OP_W       = 3;
    localparam int unsigned CSR_ADDR_W = 12;
    localparam int unsigned REG_IDX_W  = 5;

    localparam logic [OP_W-1:0] CSR_OP_RW  = 3'b001;
    localparam logic [OP_W-1:0] CSR_OP_RS  = 3'b010;
    localparam logic [OP_W-1:0] CSR_OP_RC  = 3'b011;
    localparam logic [OP_W-1:0] CSR_OP_RWI = 3'b101;
    localparam logic [OP_W-1:0] CSR_OP_RSI = 3'b110;
    localparam logic [OP_W-1:0] CSR_OP_RCI = 3'b111;

    localparam logic [1:0] CSR_RO_FIELD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_WR   = 3'd3,
        S_ILL  = 3'd4
    } state_e;

    typedef struct packed {
        logic do_read;
        logic do_write;
        logic illegal;
    } csr_ctl_t;

    // Addresses with [11:10]==2'b11 are read-only by the privileged architecture.
    function automatic logic csr_is_read_only(input logic [CSR_ADDR_W-1:0] addr);
        return addr[CSR_ADDR_W-1 -: 2] == CSR_RO_FIELD;
    endfunction

endpackage

// File: rtl/ex_csr_alu.sv
// Combinational Zicsr decode: new CSR value plus read/write suppression and legality.
module ex_csr_alu
    import ex_csr_rmw_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [OP_W-1:0]       op_i,
    input  logic [XLEN-1:0]       src_i,
    input  logic [XLEN-1:0]       old_i,
    input  logic [CSR_ADDR_W-1:0] addr_i,
    input  logic [REG_IDX_W-1:0]  rs1_idx_i,
    input  logic [REG_IDX_W-1:0]  rd_idx_i,
    output logic [XLEN-1:0]       new_o,
    output csr_ctl_t              ctl_o
);

    logic is_rw;
    logic is_set_clr;
    logic op_valid;

    always_comb begin
        new_o      = '0;
        is_rw      = 1'b0;
        is_set_clr = 1'b0;
        op_valid   = 1'b1;
        case (op_i)
            CSR_OP_RW, CSR_OP_RWI: begin
                new_o = src_i;
                is_rw = 1'b1;
            end
            CSR_OP_RS, CSR_OP_RSI: begin
                new_o      = old_i | src_i;
                is_set_clr = 1'b1;
            end
            CSR_OP_RC, CSR_OP_RCI: begin
                new_o      = old_i & ~src_i;
                is_set_clr = 1'b1;
            end
            default: op_valid = 1'b0;
        endcase
    end

    // rw with rd=x0 skips the read; set/clear with rs1/zimm=0 skips the write.
    always_comb begin
        ctl_o          = '0;
        ctl_o.do_read  = !(is_rw && (rd_idx_i == '0));
        ctl_o.do_write = !(is_set_clr && (rs1_idx_i == '0));
        ctl_o.illegal  = !op_valid || (ctl_o.do_write && csr_is_read_only(addr_i));
    end

endmodule

// File: rtl/ex_csr_rmw.sv
// Multi-cycle CSR read-modify-write engine: read old value, write new value, return old to rd.
module ex_csr_rmw
    import ex_csr_rmw_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [OP_W-1:0]       csr_op_i,
    input  logic [CSR_ADDR_W-1:0] csr_addr_i,
    input  logic [XLEN-1:0]       data_rs1_i,
    input  logic [REG_IDX_W-1:0]  rs1_idx_i,
    input  logic [XLEN-1:0]       csr_imm_i,
    input  logic [REG_IDX_W-1:0]  addr_reg_wr_i,
    input  logic                  flush_i,
    output logic                  csr_rd_req_o,
    output logic [CSR_ADDR_W-1:0] csr_rd_addr_o,
    input  logic [XLEN-1:0]       csr_rd_data_i,
    output logic                  csr_we_o,
    output logic [CSR_ADDR_W-1:0] csr_wr_addr_o,
    output logic [XLEN-1:0]       csr_wr_data_o,
    output logic                  rsp_valid_o,
    output logic                  rsp_rd_we_o,
    output logic [REG_IDX_W-1:0]  rsp_rd_addr_o,
    output logic [XLEN-1:0]       rsp_rd_data_o,
    output logic                  rsp_illegal_o
);

    localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [OP_W-1:0]         op_q, op_d;
    logic [CSR_ADDR_W-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]         src_q, src_d;
    logic [REG_IDX_W-1:0]    rs1_idx_q, rs1_idx_d;
    logic [REG_IDX_W-1:0]    rd_q, rd_d;

    logic                    rd_req_q, rd_req_d;
    logic [CSR_ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                    we_q, we_d;
    logic [CSR_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]         wr_data_q, wr_data_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_rd_we_q, rsp_rd_we_d;
    logic [REG_IDX_W-1:0]    rsp_rd_addr_q, rsp_rd_addr_d;
    logic [XLEN-1:0]         rsp_rd_data_q, rsp_rd_data_d;
    logic                    rsp_illegal_q, rsp_illegal_d;

    logic                    idle;
    logic [OP_W-1:0]         alu_op;
    logic [XLEN-1:0]         alu_src;
    logic [CSR_ADDR_W-1:0]   alu_addr;
    logic [REG_IDX_W-1:0]    alu_rs1_idx;
    logic [REG_IDX_W-1:0]    alu_rd;
    logic [XLEN-1:0]         alu_new;
    csr_ctl_t                alu_ctl;
    logic [XLEN-1:0]         req_src;

    // One decoder serves both the incoming request (IDLE) and the captured one.
    assign idle        = (state_q == S_IDLE);
    assign req_src     = csr_op_i[2] ? csr_imm_i : data_rs1_i;
    assign alu_op      = idle ? csr_op_i      : op_q;
    assign alu_src     = idle ? req_src       : src_q;
    assign alu_addr    = idle ? csr_addr_i    : addr_q;
    assign alu_rs1_idx = idle ? rs1_idx_i     : rs1_idx_q;
    assign alu_rd      = idle ? addr_reg_wr_i : rd_q;

    ex_csr_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .op_i      (alu_op),
        .src_i     (alu_src),
        .old_i     (csr_rd_data_i),
        .addr_i    (alu_addr),
        .rs1_idx_i (alu_rs1_idx),
        .rd_idx_i  (alu_rd),
        .new_o     (alu_new),
        .ctl_o     (alu_ctl)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        addr_d        = addr_q;
        src_d         = src_q;
        rs1_idx_d     = rs1_idx_q;
        rd_d          = rd_q;
        rd_req_d      = 1'b0;
        rd_addr_d     = '0;
        we_d          = 1'b0;
        wr_addr_d     = '0;
        wr_data_d     = '0;
        rsp_valid_d   = 1'b0;
        rsp_rd_we_d   = 1'b0;
        rsp_rd_addr_d = '0;
        rsp_rd_data_d = '0;
        rsp_illegal_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i && !flush_i) begin
                    op_d      = csr_op_i;
                    addr_d    = csr_addr_i;
                    src_d     = req_src;
                    rs1_idx_d = rs1_idx_i;
                    rd_d      = addr_reg_wr_i;
                    if (alu_ctl.illegal) begin
                        state_d       = S_ILL;
                        rsp_valid_d   = 1'b1;
                        rsp_illegal_d = 1'b1;
                        rsp_rd_addr_d = addr_reg_wr_i;
                    end else if (alu_ctl.do_read) begin
                        state_d   = S_RD;
                        rd_req_d  = 1'b1;
                        rd_addr_d = csr_addr_i;
                    end else begin
                        // Only rw/rwi with rd=x0 lands here, so the write is unconditional.
                        state_d       = S_WR;
                        we_d          = 1'b1;
                        wr_addr_d     = csr_addr_i;
                        wr_data_d     = alu_new;
                        rsp_valid_d   = 1'b1;
                        rsp_rd_addr_d = addr_reg_wr_i;
                    end
                end
            end
            S_RD: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(RD_LAT);
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    // Counter hits zero on this edge: read data is valid now.
                    if (cnt_q == CNT_W'(1)) begin
                        state_d       = S_WR;
                        we_d          = alu_ctl.do_write;
                        wr_addr_d     = alu_ctl.do_write ? addr_q  : '0;
                        wr_data_d     = alu_ctl.do_write ? alu_new : '0;
                        rsp_valid_d   = 1'b1;
                        rsp_rd_we_d   = (rd_q != '0);
                        rsp_rd_addr_d = rd_q;
                        rsp_rd_data_d = csr_rd_data_i;
                    end
                end
            end
            S_WR:    state_d = S_IDLE;
            S_ILL:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            op_q          <= '0;
            addr_q        <= '0;
            src_q         <= '0;
            rs1_idx_q     <= '0;
            rd_q          <= '0;
            rd_req_q      <= 1'b0;
            rd_addr_q     <= '0;
            we_q          <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rd_we_q   <= 1'b0;
            rsp_rd_addr_q <= '0;
            rsp_rd_data_q <= '0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            src_q         <= src_d;
            rs1_idx_q     <= rs1_idx_d;
            rd_q          <= rd_d;
            rd_req_q      <= rd_req_d;
            rd_addr_q     <= rd_addr_d;
            we_q          <= we_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rd_we_q   <= rsp_rd_we_d;
            rsp_rd_addr_q <= rsp_rd_addr_d;
            rsp_rd_data_q <= rsp_rd_data_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign req_ready_o   = idle;
    assign csr_rd_req_o  = rd_req_q;
    assign csr_rd_addr_o = rd_addr_q;
    assign csr_we_o      = we_q;
    assign csr_wr_addr_o = wr_addr_q;
    assign csr_wr_data_o = wr_data_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rd_we_o   = rsp_rd_we_q;
    assign rsp_rd_addr_o = rsp_rd_addr_q;
    assign rsp_rd_data_o = rsp_rd_data_q;
    assign rsp_illegal_o = rsp_illegal_q;

endmodule
